// File: rtl/v_red_unit_pkg.sv
// ---------------------------------------------------------------------------
// v_red_unit_pkg
// Shared definitions for the vector reduction unit: element width encoding
// (vsew), supported reduction opcodes (funct6), the OPM_VV funct3 encoding,
// beat geometry, FSM state encoding, and small SEW helpers used by both the
// top level and the fold datapath.
// ---------------------------------------------------------------------------
package v_red_unit_pkg;

    // Width of one vs2 beat coming from the register file read port.
    localparam int BEAT_W = 32;
    // Element slots per beat at the narrowest SEW.
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        VSEW_8       = 2'b00,
        VSEW_16      = 2'b01,
        VSEW_32      = 2'b10,
        VSEW_INVALID = 2'b11
    } vsew_e;

    typedef enum logic [5:0] {
        FUNCT6_VREDSUM = 6'b000000,
        FUNCT6_VREDMAX = 6'b000111
    } funct6_red_e;

    typedef enum logic [2:0] {
        FUNCT3_OPM_VV = 3'b010
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } red_state_e;

    // Mask selecting the low SEW bits of a beat-wide word.
    function automatic logic [BEAT_W-1:0] sew_mask(input vsew_e sew);
        case (sew)
            VSEW_8:  sew_mask = 32'h0000_00FF;
            VSEW_16: sew_mask = 32'h0000_FFFF;
            VSEW_32: sew_mask = 32'hFFFF_FFFF;
            default: sew_mask = 32'h0000_0000;
        endcase
    endfunction

    // Sign-extend the low SEW bits to a full beat-wide word.
    function automatic logic [BEAT_W-1:0] sew_sext(input logic [BEAT_W-1:0] v, input vsew_e sew);
        case (sew)
            VSEW_8:  sew_sext = {{24{v[7]}}, v[7:0]};
            VSEW_16: sew_sext = {{16{v[15]}}, v[15:0]};
            VSEW_32: sew_sext = v;
            default: sew_sext = 32'h0000_0000;
        endcase
    endfunction

    // Elements per beat (4 >> sew); zero for the reserved encoding.
    function automatic logic [2:0] sew_epb(input vsew_e sew);
        case (sew)
            VSEW_8:  sew_epb = 3'd4;
            VSEW_16: sew_epb = 3'd2;
            VSEW_32: sew_epb = 3'd1;
            default: sew_epb = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/v_red_unit_if.sv
// ---------------------------------------------------------------------------
// v_red_unit_if
// Issue + vs2 beat stream + completion bundle of the vector reduction unit.
//   i_start/i_funct6/i_sew/i_vl/i_scalar : instruction issue
//   i_beat_valid/i_beat_data/o_beat_ready : vs2 beat handshake
//   i_beat_mask                           : per-slot element mask (only when
//                                           VRED_MASK_EN is defined)
//   o_busy/o_done/o_we/o_illegal/o_result : status and writeback result
// Modports: master = issuing side, slave = reduction unit.
// ---------------------------------------------------------------------------
interface v_red_unit_if
    import v_red_unit_pkg::*;
#(
    parameter int VLW = 8
);
    logic              i_start;
    logic [5:0]        i_funct6;
    logic [1:0]        i_sew;
    logic [VLW-1:0]    i_vl;
    logic [BEAT_W-1:0] i_scalar;
    logic              i_beat_valid;
    logic [BEAT_W-1:0] i_beat_data;
`ifdef VRED_MASK_EN
    logic [LANES-1:0]  i_beat_mask;
`endif
    logic              o_beat_ready;
    logic              o_busy;
    logic              o_done;
    logic              o_we;
    logic              o_illegal;
    logic [BEAT_W-1:0] o_result;

`ifdef VRED_MASK_EN
    modport master (
        output i_start, i_funct6, i_sew, i_vl, i_scalar, i_beat_valid, i_beat_data, i_beat_mask,
        input  o_beat_ready, o_busy, o_done, o_we, o_illegal, o_result
    );
    modport slave (
        input  i_start, i_funct6, i_sew, i_vl, i_scalar, i_beat_valid, i_beat_data, i_beat_mask,
        output o_beat_ready, o_busy, o_done, o_we, o_illegal, o_result
    );
`else
    modport master (
        output i_start, i_funct6, i_sew, i_vl, i_scalar, i_beat_valid, i_beat_data,
        input  o_beat_ready, o_busy, o_done, o_we, o_illegal, o_result
    );
    modport slave (
        input  i_start, i_funct6, i_sew, i_vl, i_scalar, i_beat_valid, i_beat_data,
        output o_beat_ready, o_busy, o_done, o_we, o_illegal, o_result
    );
`endif

endinterface

// File: rtl/v_red_fold.sv
// ---------------------------------------------------------------------------
// v_red_fold
// Combinational SEW-aware fold of up to four beat elements into the running
// accumulator (sum modulo 2^SEW, or signed maximum).
//   sew     in  element width
//   op_max  in  1 = signed max, 0 = wrapping sum
//   acc     in  current accumulator, low SEW bits valid
//   data    in  beat, element 0 in the low SEW bits
//   lane_en in  per-slot enable (already qualified by vl, EPB and mask)
//   result  out folded accumulator, zero-extended to 32 bits
// ---------------------------------------------------------------------------
module v_red_fold
    import v_red_unit_pkg::*;
(
    input  vsew_e             sew,
    input  logic              op_max,
    input  logic [BEAT_W-1:0] acc,
    input  logic [BEAT_W-1:0] data,
    input  logic [LANES-1:0]  lane_en,
    output logic [BEAT_W-1:0] result
);

    logic [BEAT_W-1:0] elem_s   [LANES];
    logic [BEAT_W-1:0] elem_sx_s[LANES];
    logic [BEAT_W-1:0] acc_sx_s;
    logic [BEAT_W-1:0] sum_s;
    logic [BEAT_W-1:0] max_s;

    // Split the beat into element slots according to SEW.
    always_comb begin
        for (int e = 0; e < LANES; e++) begin
            elem_s[e] = 32'h0000_0000;
        end
        case (sew)
            VSEW_8: begin
                elem_s[0] = {24'h000000, data[7:0]};
                elem_s[1] = {24'h000000, data[15:8]};
                elem_s[2] = {24'h000000, data[23:16]};
                elem_s[3] = {24'h000000, data[31:24]};
            end
            VSEW_16: begin
                elem_s[0] = {16'h0000, data[15:0]};
                elem_s[1] = {16'h0000, data[31:16]};
            end
            VSEW_32: begin
                elem_s[0] = data;
            end
            default: begin
                elem_s[0] = 32'h0000_0000;
            end
        endcase
    end

    // Sign-extended operands let one 32-bit adder and comparator serve every
    // SEW: the sum is truncated afterwards, and the compare is exact.
    always_comb begin
        acc_sx_s = sew_sext(acc, sew);
        sum_s    = acc_sx_s;
        max_s    = acc_sx_s;
        for (int e = 0; e < LANES; e++) begin
            elem_sx_s[e] = sew_sext(elem_s[e], sew);
            if (lane_en[e]) begin
                sum_s = sum_s + elem_sx_s[e];
            end else begin
                sum_s = sum_s;
            end
            if (lane_en[e] && ($signed(elem_sx_s[e]) > $signed(max_s))) begin
                max_s = elem_sx_s[e];
            end else begin
                max_s = max_s;
            end
        end
        if (op_max) begin
            result = max_s & sew_mask(sew);
        end else begin
            result = sum_s & sew_mask(sew);
        end
    end

endmodule

// File: rtl/v_red_unit.sv
// ---------------------------------------------------------------------------
// v_red_unit
// Vector reduction unit (VREDSUM / VREDMAX, OPM_VV). Latches the instruction
// on i_start, folds streamed vs2 beats into a SEW-wide accumulator seeded
// with vs1[0], and reports one zero-extended result for vd[0].
//   clk, rst : clock, synchronous active-high reset
//   bus      : v_red_unit_if slave modport (issue, beat stream, completion)
// Optional feature: define VRED_MASK_EN to add per-slot element masking via
// bus.i_beat_mask; otherwise every element slot is active.
// ---------------------------------------------------------------------------
module v_red_unit
    import v_red_unit_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int VLW  = 8
)(
    input  logic         clk,
    input  logic         rst,
    v_red_unit_if.slave  bus
);

    // Element counter overshoots vl by up to EPB-1 on the final beat, so it
    // carries one bit more than the widest vl it must compare against.
    localparam int CNT_W = ((VLW + 1) > ($clog2(VLEN) + 1)) ? (VLW + 1) : ($clog2(VLEN) + 1);

    red_state_e        state_q,   state_d;
    logic [5:0]        funct6_q,  funct6_d;
    vsew_e             sew_q,     sew_d;
    logic [CNT_W-1:0]  vl_q,      vl_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [BEAT_W-1:0] acc_q,     acc_d;
    logic [BEAT_W-1:0] result_q,  result_d;
    logic              we_q,      we_d;
    logic              illegal_q, illegal_d;
    logic              done_q,    done_d;
    logic              busy_q,    busy_d;
    logic              ready_q,   ready_d;

    logic [2:0]        epb_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              beat_fire_s;
    logic              start_illegal_s;
    logic              op_max_s;
    logic [LANES-1:0]  mask_s;
    logic [LANES-1:0]  lane_en_s;
    logic [BEAT_W-1:0] fold_s;

`ifdef VRED_MASK_EN
    assign mask_s = bus.i_beat_mask;
`else
    assign mask_s = 4'b1111;
`endif

    assign epb_s           = sew_epb(sew_q);
    assign cnt_next_s      = cnt_q + CNT_W'(epb_s);
    assign beat_fire_s     = bus.i_beat_valid && (state_q == ST_ACCUM);
    assign op_max_s        = (funct6_q == FUNCT6_VREDMAX);
    assign start_illegal_s = (bus.i_sew == VSEW_INVALID) ||
                             !((bus.i_funct6 == FUNCT6_VREDSUM) || (bus.i_funct6 == FUNCT6_VREDMAX));

    // A slot is folded only if it exists at this SEW, lies below vl, and is unmasked.
    always_comb begin
        lane_en_s = 4'b0000;
        for (int e = 0; e < LANES; e++) begin
            if ((3'(e) < epb_s) && ((cnt_q + CNT_W'(e)) < vl_q) && mask_s[e]) begin
                lane_en_s[e] = 1'b1;
            end else begin
                lane_en_s[e] = 1'b0;
            end
        end
    end

    v_red_fold u_fold (
        .sew     (sew_q),
        .op_max  (op_max_s),
        .acc     (acc_q),
        .data    (bus.i_beat_data),
        .lane_en (lane_en_s),
        .result  (fold_s)
    );

    // Next-state and next-register logic for the IDLE/ACCUM/DONE sequence.
    always_comb begin
        state_d   = state_q;
        funct6_d  = funct6_q;
        sew_d     = sew_q;
        vl_d      = vl_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        result_d  = result_q;
        we_d      = we_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    funct6_d  = bus.i_funct6;
                    sew_d     = vsew_e'(bus.i_sew);
                    vl_d      = CNT_W'(bus.i_vl);
                    acc_d     = bus.i_scalar & sew_mask(vsew_e'(bus.i_sew));
                    cnt_d     = {CNT_W{1'b0}};
                    // Previous result and flags stay visible until this point.
                    result_d  = 32'h0000_0000;
                    we_d      = 1'b0;
                    illegal_d = 1'b0;
                    if (start_illegal_s) begin
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (bus.i_vl == {VLW{1'b0}}) begin
                        state_d   = ST_DONE;
                    end else begin
                        state_d   = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (beat_fire_s) begin
                    acc_d = fold_s;
                    cnt_d = cnt_next_s;
                    if (cnt_next_s >= vl_q) begin
                        result_d = fold_s;
                        we_d     = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status outputs are registered copies of the next state's decode.
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_ACCUM);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            funct6_q  <= 6'b000000;
            sew_q     <= VSEW_8;
            vl_q      <= {CNT_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= 32'h0000_0000;
            result_q  <= 32'h0000_0000;
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct6_q  <= funct6_d;
            sew_q     <= sew_d;
            vl_q      <= vl_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            we_q      <= we_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.o_beat_ready = ready_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_we         = we_q;
    assign bus.o_illegal    = illegal_q;
    assign bus.o_result     = result_q;

endmodule

// File: tb/tb_v_red_unit.sv
// ---------------------------------------------------------------------------
// tb_v_red_unit
// Scoreboard bench for v_red_unit: each issued instruction pushes the result
// predicted by a reference model onto a queue; an independent monitor pops
// and compares whenever o_done is seen. Directed cases plus randomized ops.
// ---------------------------------------------------------------------------
module tb_v_red_unit;
    import v_red_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    v_red_unit_if #(.VLW(8)) bus ();

    v_red_unit #(.VLEN(128), .VLW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        we;
        logic        illegal;
        logic [31:0] result;
        bit          chk_res;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] elem_q[$];
    bit          mask_q[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] wmask(input logic [1:0] sew);
        case (sew)
            2'd0: return 32'h0000_00FF;
            2'd1: return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic longint to_signed(input longint v, input longint w);
        longint half;
        half = longint'(1) << (w - 1);
        return (v >= half) ? v - (half * 2) : v;
    endfunction

    // Reference: fold the active elements one at a time in plain arithmetic.
    function automatic exp_t model(input logic [5:0] f6, input logic [1:0] sew, input int vl,
                                   input logic [31:0] scalar);
        exp_t   e;
        longint w, modv, acc, v;
        e.chk_res = 1'b1;
        if (sew == 2'b11 || !(f6 == FUNCT6_VREDSUM || f6 == FUNCT6_VREDMAX)) begin
            e.we = 1'b0; e.illegal = 1'b1; e.result = 32'h0; e.chk_res = 1'b0;
        end else if (vl == 0) begin
            e.we = 1'b0; e.illegal = 1'b0; e.result = 32'h0;
        end else begin
            w    = 8 << sew;
            modv = longint'(1) << w;
            acc  = longint'({32'h0, scalar}) % modv;
            for (int i = 0; i < vl; i++) begin
                if (mask_q[i]) begin
                    v = longint'({32'h0, elem_q[i]});
                    if (f6 == FUNCT6_VREDSUM) acc = (acc + v) % modv;
                    else if (to_signed(v, w) > to_signed(acc, w)) acc = v;
                end
            end
            e.we = 1'b1; e.illegal = 1'b0; e.result = acc[31:0];
        end
        return e;
    endfunction

    task automatic fill_rand(input int vl, input logic [1:0] sew, input bit rand_mask);
        elem_q.delete();
        mask_q.delete();
        for (int i = 0; i < vl; i++) begin
            elem_q.push_back($urandom & wmask(sew));
            mask_q.push_back(rand_mask ? bit'($urandom_range(1, 0)) : 1'b1);
        end
    endtask

    // Monitor: compare every completion against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got o_done=1 expected no completion");
                end else begin
                    e = exp_q.pop_front();
                    check("o_we", bus.o_we, e.we);
                    check("o_illegal", bus.o_illegal, e.illegal);
                    if (e.chk_res) check("o_result", bus.o_result, e.result);
                end
            end
        end
    end

    task automatic run_op(input logic [5:0] f6, input logic [1:0] sew, input int vl,
                          input logic [31:0] scalar, input int fixed_gap, input int rand_gap,
                          input int junk, input bit start_in_accum, input bit chk_lat);
        exp_t        e;
        int          epb, w, nbeats, s_cyc, prev, g, idx, guard;
        logic [63:0] data;
        logic [3:0]  m;
        logic [31:0] jv;
        bit          legal;
        e     = model(f6, sew, vl, scalar);
        exp_q.push_back(e);
        legal = (sew != 2'b11) && (f6 == FUNCT6_VREDSUM || f6 == FUNCT6_VREDMAX);
        epb   = legal ? (4 >> sew) : 1;
        w     = legal ? (8 << sew) : 8;
        nbeats = (legal && vl > 0) ? (vl + epb - 1) / epb : 0;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_funct6 = f6; bus.i_sew = sew;
        bus.i_vl = 8'(vl); bus.i_scalar = scalar;
        s_cyc = cyc;
        prev  = done_cnt;
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_funct6 = 6'($urandom); bus.i_sew = 2'($urandom);
        bus.i_vl = 8'($urandom); bus.i_scalar = $urandom;
        for (int b = 0; b < nbeats; b++) begin
            g = fixed_gap + $urandom_range(rand_gap, 0);
            for (int k = 0; k < g; k++) begin
                bus.i_beat_valid = 1'b0;
                bus.i_beat_data  = $urandom;
                if (start_in_accum && b == 1 && k == 0) begin
                    bus.i_start = 1'b1; bus.i_funct6 = FUNCT6_VREDSUM; bus.i_sew = 2'b00;
                    bus.i_vl = 8'd1; bus.i_scalar = 32'h0000_0077;
                end else begin
                    bus.i_start = 1'b0;
                end
                @(negedge clk);
            end
            bus.i_start = 1'b0;
            data = 64'h0;
            m    = 4'b0000;
            for (int s = 0; s < 4; s++) begin
                idx = b * epb + s;
                if (s < epb && idx < vl) begin
                    jv = elem_q[idx];
                    m[s] = mask_q[idx];
                end else begin
                    jv = (junk == 1) ? 32'hAAAA_AAAA : ((junk == 2) ? $urandom : 32'h0);
                    m[s] = 1'($urandom_range(1, 0));
                end
                if (s < epb) data = data | ({32'h0, jv & wmask(sew)} << (s * w));
            end
            bus.i_beat_valid = 1'b1;
            bus.i_beat_data  = data[31:0];
`ifdef VRED_MASK_EN
            bus.i_beat_mask  = m;
`endif
            guard = 0;
            while (bus.o_beat_ready !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                total++; bad++;
                $display("FAIL beat_ready_timeout: got o_beat_ready=0 expected 1 within 100 cycles");
                break;
            end
            @(negedge clk);
        end
        bus.i_beat_valid = 1'b0;
        #1;
        guard = 0;
        while (done_cnt == prev && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("done_count", 64'(done_cnt - prev), 64'd1);
        if (chk_lat) check("latency", 64'(done_cyc - s_cyc), 64'(nbeats + 1));
        repeat (3) @(negedge clk);
        check("hold_we", bus.o_we, e.we);
        check("hold_illegal", bus.o_illegal, e.illegal);
        if (e.chk_res) check("hold_result", bus.o_result, e.result);
        check("idle_busy", bus.o_busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int prev;
        logic [5:0] f6;
        logic [1:0] sew;
        int r, vl;
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_funct6 = 6'b0; bus.i_sew = 2'b0; bus.i_vl = 8'd0;
        bus.i_scalar = 32'h0; bus.i_beat_valid = 1'b0; bus.i_beat_data = 32'h0;
`ifdef VRED_MASK_EN
        bus.i_beat_mask = 4'b1111;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_ready", bus.o_beat_ready, 1'b0);
        check("rst_done", bus.o_done, 1'b0);
        check("rst_we", bus.o_we, 1'b0);
        check("rst_illegal", bus.o_illegal, 1'b0);
        check("rst_result", bus.o_result, 32'h0);

        // VREDSUM sew8 vl=6: 10 + 1..6 = 0x1F, clean and junk upper bytes.
        elem_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        mask_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_op(FUNCT6_VREDSUM, 2'd0, 6, 32'd10, 0, 0, 0, 1'b0, 1'b1);
        run_op(FUNCT6_VREDSUM, 2'd0, 6, 32'd10, 0, 0, 1, 1'b0, 1'b1);
        // VREDMAX sew16 signed.
        elem_q = '{32'hFFFE, 32'h0005, 32'h7FF0};
        mask_q = '{1'b1, 1'b1, 1'b1};
        run_op(FUNCT6_VREDMAX, 2'd1, 3, 32'h0000_8000, 0, 0, 2, 1'b0, 1'b1);
        // Wrap-around sums.
        elem_q = '{32'h02}; mask_q = '{1'b1};
        run_op(FUNCT6_VREDSUM, 2'd0, 1, 32'h0000_00FF, 0, 0, 2, 1'b0, 1'b1);
        elem_q = '{32'h1}; mask_q = '{1'b1};
        run_op(FUNCT6_VREDSUM, 2'd2, 1, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 1'b1);
        // vl=0 and illegal encodings complete one cycle after start.
        run_op(FUNCT6_VREDSUM, 2'd0, 0, 32'h0000_0055, 0, 0, 0, 1'b0, 1'b1);
        run_op(FUNCT6_VREDSUM, 2'd3, 4, 32'h0000_0012, 0, 0, 0, 1'b0, 1'b1);
        run_op(6'b000010,      2'd0, 4, 32'h0000_0012, 0, 0, 0, 1'b0, 1'b1);
        // Backpressure with 3-cycle gaps and a stray start during ACCUM.
        fill_rand(10, 2'd0, 1'b0);
        run_op(FUNCT6_VREDSUM, 2'd0, 10, 32'h0000_0033, 3, 0, 2, 1'b1, 1'b0);
        fill_rand(9, 2'd1, 1'b0);
        run_op(FUNCT6_VREDMAX, 2'd1, 9, 32'h0000_8001, 3, 0, 2, 1'b1, 1'b0);

        // Reset mid-ACCUM aborts without completion.
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_funct6 = FUNCT6_VREDSUM; bus.i_sew = 2'd0;
        bus.i_vl = 8'd8; bus.i_scalar = 32'h5;
        prev = done_cnt;
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_beat_valid = 1'b1; bus.i_beat_data = 32'h0101_0101;
`ifdef VRED_MASK_EN
        bus.i_beat_mask = 4'b1111;
`endif
        @(negedge clk);
        bus.i_beat_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.o_busy, 1'b0);
        check("abort_ready", bus.o_beat_ready, 1'b0);
        check("abort_result", bus.o_result, 32'h0);
        repeat (4) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - prev), 64'd0);
        elem_q = '{32'h10, 32'h20, 32'h30}; mask_q = '{1'b1, 1'b1, 1'b1};
        run_op(FUNCT6_VREDSUM, 2'd2, 3, 32'h0000_0001, 0, 0, 0, 1'b0, 1'b1);

`ifdef VRED_MASK_EN
        elem_q = '{32'h1, 32'h2, 32'h3, 32'h4}; mask_q = '{1'b1, 1'b0, 1'b1, 1'b0};
        run_op(FUNCT6_VREDSUM, 2'd0, 4, 32'h0, 0, 0, 0, 1'b0, 1'b1);
        mask_q = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_op(FUNCT6_VREDSUM, 2'd0, 4, 32'h0000_0007, 0, 0, 0, 1'b0, 1'b1);
`endif

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            r   = $urandom_range(9, 0);
            sew = 2'($urandom_range(2, 0));
            f6  = (r < 4) ? FUNCT6_VREDSUM : FUNCT6_VREDMAX;
            if (r == 8) f6 = 6'b000010;
            if (r == 9) sew = 2'b11;
            vl  = $urandom_range(16, 0);
`ifdef VRED_MASK_EN
            fill_rand(vl, sew, 1'b1);
`else
            fill_rand(vl, sew, 1'b0);
`endif
            run_op(f6, sew, vl, $urandom, 0, 2, 2, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
